// File: rtl/fp_pkg.sv
// Shared constants, field widths and FSM state encoding for the integer to
// single-precision float converter.
package fp_pkg;

  localparam int FP_BIAS     = 127;
  localparam int INT_EXP_MAX = 158;
  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Magnitude of a 32-bit word; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/round_nearest_even.sv
// Combinational round-to-nearest-even increment of a 23-bit fraction.
module round_nearest_even
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_out,
  output logic              carry
);

  logic inc;

  assign inc               = guard & (sticky | frac[0]);
  assign {carry, frac_out} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};

endmodule

// File: rtl/int_to_float.sv
// Sequential 32-bit integer to IEEE754 single converter (one shift per cycle).
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates.
module int_to_float
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        signed_in,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        inexact
);

  state_t            state, state_nxt;
  logic              sign;
  logic [31:0]       mag;
  logic [EXP_W-1:0]  exp_q;

  logic              neg_in;
  logic [31:0]       mag_in;
  logic [FRAC_W-1:0] frac_raw, frac_rnd;
  logic              guard, sticky, carry;

  assign neg_in   = signed_in & in_data[31];
  assign mag_in   = abs32(in_data, neg_in);

  assign frac_raw = mag[30:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];

`ifdef ROUND_NEAREST_EN
  round_nearest_even u_rne (
    .frac     (frac_raw),
    .guard    (guard),
    .sticky   (sticky),
    .frac_out (frac_rnd),
    .carry    (carry)
  );
`else
  assign frac_rnd = frac_raw;
  assign carry    = 1'b0;
`endif

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (mag_in == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Exponent starts at the value for a set bit 31 and drops once per shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign    <= 1'b0;
      mag     <= '0;
      exp_q   <= '0;
      result  <= '0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign  <= neg_in;
          mag   <= mag_in;
          exp_q <= INT_EXP_MAX[EXP_W-1:0];
          if (mag_in == 32'd0) begin
            result  <= '0;
            inexact <= 1'b0;
          end
        end
        NORM: if (!mag[31]) begin
          mag   <= mag << 1;
          exp_q <= exp_q - 1'b1;
        end
        ROUND: begin
          result  <= {sign, exp_q + {{(EXP_W-1){1'b0}}, carry}, frac_rnd};
          inexact <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: expectations queued at issue, checked on done.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_data;
  logic        signed_in;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        inexact;

  int_to_float dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .signed_in (signed_in),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference conversion by locating the top set bit and rounding the remainder.
  function automatic void ref_conv(input logic [31:0] d, input logic s,
                                   output logic [31:0] r, output logic inx, output int lat);
    logic        neg;
    logic [63:0] m, kept, rem, half;
    int          p, e, sh;
    neg = s & d[31];
    m   = {32'd0, neg ? (~d + 32'd1) : d};
    p   = -1;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p < 0) begin
      r = 32'd0; inx = 1'b0; lat = 0;
      return;
    end
    lat = 33 - p;
    e   = 127 + p;
    if (p <= 23) begin
      kept = m << (23 - p);
      inx  = 1'b0;
    end else begin
      sh   = p - 23;
      kept = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
`ifdef ROUND_NEAREST_EN
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (kept[24]) begin
        kept = kept >> 1;
        e++;
      end
`endif
    end
    r = {neg, e[7:0], kept[22:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("result",  result,  e.res);
        chk("inexact", {31'd0, inexact}, {31'd0, e.inx});
        chk("latency", 32'(cyc - e.e0), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic issue(input logic [31:0] d, input logic s,
                       input logic [31:0] r, input logic inx, input int lat);
    wait_idle();
    start = 1'b1; in_data = d; signed_in = s;
    sb.push_back('{r, inx, cyc + 1, lat});
    @(posedge clk); #1;
    start     = 1'b0;
    in_data   = $urandom;
    signed_in = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_m(input logic [31:0] d, input logic s);
    logic [31:0] r;
    logic        inx;
    int          lat;
    ref_conv(d, s, r, inx, lat);
    issue(d, s, r, inx, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e0;
    rst = 1'b1; start = 1'b0; in_data = '0; signed_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result",  result, 32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    rst = 1'b0;

    issue(32'd1,          1'b1, 32'h3F800000, 1'b0, 33);
    issue(32'hFFFFFFFF,   1'b1, 32'hBF800000, 1'b0, 33);
    issue(32'd0,          1'b1, 32'h00000000, 1'b0, 0);
    issue(32'h80000000,   1'b1, 32'hCF000000, 1'b0, 2);
`ifdef ROUND_NEAREST_EN
    issue(32'hFFFFFFFF,   1'b0, 32'h4F800000, 1'b1, 2);
    issue(32'd16777219,   1'b0, 32'h4B800002, 1'b1, 9);
`else
    issue(32'hFFFFFFFF,   1'b0, 32'h4F7FFFFF, 1'b1, 2);
    issue(32'd16777219,   1'b0, 32'h4B800001, 1'b1, 9);
`endif
    issue(32'd16777217,   1'b0, 32'h4B800000, 1'b1, 9);
    issue(32'd0,          1'b0, 32'h00000000, 1'b0, 0);

    for (int i = 0; i < 12; i++)
      issue_m($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    drain();

    // Start held high: each acceptance waits for the IDLE edge after done.
    c = cyc;
    start = 1'b1; in_data = 32'd3; signed_in = 1'b1;
    sb.push_back('{32'h40400000, 1'b0, c + 1,  32});
    sb.push_back('{32'h40400000, 1'b0, c + 35, 32});
    sb.push_back('{32'h40400000, 1'b0, c + 69, 32});
    while (cyc < c + 69) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain();

    // Abort mid-normalisation with stray starts, then restart right after reset.
    start = 1'b1; in_data = 32'd1; signed_in = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    for (int i = 0; i < 10; i++) begin
      start   = (i == 2 || i == 5);
      in_data = 32'd7;
      rst     = (i == 9);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("abort_edge",    32'(cyc - e0), 32'd10);
    chk("abort_busy",    {31'd0, busy},    32'd0);
    chk("abort_done",    {31'd0, done},    32'd0);
    chk("abort_result",  result, 32'd0);
    chk("abort_inexact", {31'd0, inexact}, 32'd0);
    rst = 1'b0;
    issue(32'd5, 1'b1, 32'h40A00000, 1'b0, 31);
    drain();

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; in_data = 32'd5; signed_in = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    issue_m(32'h00012345, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
